// File: rtl/lms_pkg.sv
// -----------------------------------------------------------------------------
// lms_pkg
// Shared types and constants for the leaky-LMS coefficient update engine.
//   W         : sample / error / weight width (signed Q1.31)
//   LEAK_NUM  : numerator of the 0.999 leak ratio
//   LEAK_DEN  : denominator of the leak ratio
//   prod_t    : 64-bit signed product type used for all wide intermediates
//   state_t   : update-pass FSM states
//   sat32     : clip a 33-bit signed sum to the 32-bit signed range
// -----------------------------------------------------------------------------
package lms_pkg;

    localparam int W = 32;

    localparam logic signed [W-1:0] LEAK_NUM = 32'sh7FDF3B63;
    localparam logic signed [W-1:0] LEAK_DEN = 32'sh7FFFFFFF;

    typedef logic signed [2*W-1:0] prod_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic signed [W-1:0] sat32(input logic signed [W:0] s);
        logic signed [W-1:0] r;
        // Overflow shows up as the two top bits disagreeing.
        if (s[W] != s[W-1]) begin
            r = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            r = s[W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/lms_tap_update.sv
// -----------------------------------------------------------------------------
// lms_tap_update
// Combinational single-tap leaky-LMS datapath:
//   w_new = leak(w) + clamp((err * x) >>> MU_SHIFT)
// Build option: LMS_WEIGHT_SAT_EN
//   defined   -> the 33-bit sum saturates to the 32-bit signed range
//   undefined -> the low 32 bits of the sum are kept (wraps)
// The delta clamp is present in both builds.
//
// Ports
//   w      in   W  current weight (signed)
//   x      in   W  reference sample for this tap (signed)
//   err    in   W  latched error sample (signed)
//   w_new  out  W  updated weight
// -----------------------------------------------------------------------------
module lms_tap_update
    import lms_pkg::*;
#(
    parameter int MU_SHIFT = 12
) (
    input  logic signed [W-1:0] w,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] err,
    output logic signed [W-1:0] w_new
);

    localparam prod_t DELTA_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam prod_t DELTA_MIN = 64'shFFFF_FFFF_8000_0000;

    prod_t               leak_prod;
    prod_t               leak_quot;
    prod_t               err_prod;
    prod_t               err_shift;
    logic signed [W-1:0] leak;
    logic signed [W-1:0] delta;
    logic signed [W:0]   sum;

    always_comb begin
        // Signed division truncates toward zero, so small negative weights
        // leak to 0 rather than sticking at -1.
        leak_prod = prod_t'(w) * prod_t'(LEAK_NUM);
        leak_quot = leak_prod / prod_t'(LEAK_DEN);
        leak      = leak_quot[W-1:0];

        err_prod  = prod_t'(err) * prod_t'(x);
        err_shift = err_prod >>> MU_SHIFT;
        if (err_shift > DELTA_MAX) begin
            delta = DELTA_MAX[W-1:0];
        end else if (err_shift < DELTA_MIN) begin
            delta = DELTA_MIN[W-1:0];
        end else begin
            delta = err_shift[W-1:0];
        end

        sum = {leak[W-1], leak} + {delta[W-1], delta};

`ifdef LMS_WEIGHT_SAT_EN
        w_new = sat32(sum);
`else
        w_new = sum[W-1:0];
`endif
    end

    // The quotient always fits in W bits; the upper half is never needed.
    logic unused_bits;
`ifdef LMS_WEIGHT_SAT_EN
    assign unused_bits = ^leak_quot[2*W-1:W];
`else
    assign unused_bits = ^{leak_quot[2*W-1:W], sum[W]};
`endif

endmodule

// File: rtl/lms_weight_update.sv
// -----------------------------------------------------------------------------
// lms_weight_update
// Leaky-LMS coefficient update engine. Holds the reference delay line and the
// weight bank; each pass sweeps every tap once through lms_tap_update.
// Build option: LMS_WEIGHT_SAT_EN (see lms_tap_update).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; delay line may shift
//   SWEEP | one tap per cycle: w[idx] <- update(w[idx], x[idx])
//   DONE  | one-cycle completion, done pulse
//
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   x_valid    in   1        shift x_in into the delay line
//   x_in       in   W        new reference sample
//   start      in   1        begin an update pass (IDLE only)
//   err        in   W        error sample, latched on start
//   busy       out  1        pass in progress
//   done       out  1        one-cycle pulse at pass completion
//   overrun    out  1        sticky: x_valid seen while busy
//   w_rd_addr  in   AW       weight read index
//   w_rd_data  out  W        w[w_rd_addr], 0 when out of range
// -----------------------------------------------------------------------------
module lms_weight_update
    import lms_pkg::*;
#(
    parameter int N_TAPS   = 16,
    parameter int MU_SHIFT = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      x_valid,
    input  logic [W-1:0]              x_in,
    input  logic                      start,
    input  logic [W-1:0]              err,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun,
    input  logic [$clog2(N_TAPS)-1:0] w_rd_addr,
    output logic [W-1:0]              w_rd_data
);

    localparam int             AW       = $clog2(N_TAPS);
    localparam logic [AW-1:0]  LAST_IDX = AW'(N_TAPS - 1);

    logic signed [W-1:0] x_line [N_TAPS];
    logic signed [W-1:0] w_bank [N_TAPS];
    state_t              state;
    logic [AW-1:0]       idx;
    logic signed [W-1:0] err_l;
    logic signed [W-1:0] w_new;

    lms_tap_update #(
        .MU_SHIFT (MU_SHIFT)
    ) u_tap (
        .w     (w_bank[idx]),
        .x     (x_line[idx]),
        .err   (err_l),
        .w_new (w_new)
    );

    // Delay line freezes for the whole pass so every tap sees a consistent
    // snapshot; samples arriving meanwhile are dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                x_line[k] <= '0;
            end
            overrun <= 1'b0;
        end else if (x_valid) begin
            if (busy) begin
                overrun <= 1'b1;
            end else begin
                x_line[0] <= x_in;
                for (int k = 1; k < N_TAPS; k++) begin
                    x_line[k] <= x_line[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            err_l <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                w_bank[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err_l <= err;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= SWEEP;
                    end
                end
                SWEEP: begin
                    w_bank[idx] <= w_new;
                    if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Range check only exists when the address space is larger than the bank.
    if (N_TAPS == (1 << AW)) begin : g_rd_full
        assign w_rd_data = w_bank[w_rd_addr];
    end else begin : g_rd_part
        assign w_rd_data = (w_rd_addr <= LAST_IDX) ? w_bank[w_rd_addr] : '0;
    end

endmodule

// File: tb/tb_lms_weight_update.sv
module tb_lms_weight_update;

    localparam int N  = 12;
    localparam int MU = 12;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          x_valid = 1'b0;
    logic [31:0]   x_in = '0;
    logic          start = 1'b0;
    logic [31:0]   err = '0;
    logic          busy, done, overrun;
    logic [AW-1:0] w_rd_addr = '0;
    logic [31:0]   w_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    lms_weight_update #(
        .N_TAPS   (N),
        .MU_SHIFT (MU)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_valid   (x_valid),
        .x_in      (x_in),
        .start     (start),
        .err       (err),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun),
        .w_rd_addr (w_rd_addr),
        .w_rd_data (w_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          rst;
        bit          shf;
        logic [31:0] x;
        bit          pass;
        logic [31:0] e;
        int          addr;
        logic [31:0] exp_w;
    } vec_t;

    vec_t vt[$];

    task automatic add_vec(input bit r, input bit s, input logic [31:0] xv, input bit p,
                           input logic [31:0] ev, input int a, input logic [31:0] ex);
        vec_t v;
        v.rst = r; v.shf = s; v.x = xv; v.pass = p; v.e = ev; v.addr = a; v.exp_w = ex;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic read_w(input int a, output logic [31:0] d);
        w_rd_addr = AW'(a);
        #1;
        d = w_rd_data;
    endtask

    task automatic do_reset;
        rst_n   = 1'b0;
        x_valid = 1'b0;
        start   = 1'b0;
        x_in    = '0;
        err     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic shift_x(input logic [31:0] v);
        @(negedge clk);
        x_valid = 1'b1;
        x_in    = v;
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check({tag, " idle reached"}, 32'(busy), 32'd0);
    endtask

    // Runs one pass and checks busy/done timing. At sweep sample 'inj' a
    // stray x_valid and start are injected (inj < 0: none).
    task automatic run_pass(input logic [31:0] e, input int inj, input string tag);
        int cyc    = 0;
        int dcount = 0;
        int dcyc   = -1;
        @(negedge clk);
        start = 1'b1;
        err   = e;
        @(posedge clk); #1;
        start = 1'b0;
        while (busy && cyc < 100) begin
            if (done) begin
                dcount++;
                dcyc = cyc;
            end
            if (inj >= 0 && cyc == inj) begin
                check({tag, " overrun before"}, 32'(overrun), 32'd0);
                x_valid = 1'b1;
                start   = 1'b1;
                x_in    = 32'd7;
            end else begin
                x_valid = 1'b0;
                start   = 1'b0;
            end
            if (inj >= 0 && cyc == inj + 1) begin
                check({tag, " overrun after"}, 32'(overrun), 32'd1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        x_valid = 1'b0;
        start   = 1'b0;
        check({tag, " busy cycles"}, 32'(cyc), 32'(N + 1));
        check({tag, " done count"}, 32'(dcount), 32'd1);
        check({tag, " done cycle"}, 32'(dcyc), 32'(N));
    endtask

    logic [31:0] d;

    initial begin
        // ---- reset state and an err=0 pass ----
        do_reset;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        for (int k = 0; k < N; k++) begin
            read_w(k, d);
            check($sformatf("rst w[%0d]", k), d, 32'd0);
        end
        run_pass(32'd0, -1, "zero pass");
        read_w(0, d);  check("zero pass w[0]", d, 32'd0);
        read_w(11, d); check("zero pass w[11]", d, 32'd0);

        // ---- table-driven update vectors ----
        add_vec(1, 1, 32'h0000_0001, 1, 32'd4096,      0, 32'h0000_0001);
        add_vec(0, 0, 32'h0,         0, 32'd0,         1, 32'h0000_0000);
        add_vec(0, 0, 32'h0,         1, 32'd0,         0, 32'h0000_0000);
        add_vec(0, 1, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF);
        add_vec(0, 0, 32'h0,         0, 32'd0,         1, 32'h0007_FFFF);
`ifdef LMS_WEIGHT_SAT_EN
        add_vec(0, 0, 32'h0,         1, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF);
`else
        add_vec(0, 0, 32'h0,         1, 32'h7FFF_FFFF, 0, 32'hFFDF_3B62);
`endif
        add_vec(0, 0, 32'h0,         0, 32'd0,         1, 32'h000F_FDF1);
`ifdef LMS_WEIGHT_SAT_EN
        add_vec(0, 0, 32'h0,         1, 32'd0,         0, 32'h7FDF_3B63);
`else
        add_vec(0, 0, 32'h0,         1, 32'd0,         0, 32'hFFDF_43C6);
`endif
        add_vec(0, 0, 32'h0,         0, 32'd0,         2, 32'h0000_0000);
        add_vec(0, 0, 32'h0,         0, 32'd0,        12, 32'h0000_0000);
        add_vec(0, 0, 32'h0,         0, 32'd0,        15, 32'h0000_0000);
        add_vec(1, 1, 32'hFFFF_FFFF, 1, 32'd4096,      0, 32'hFFFF_FFFF);
        add_vec(0, 0, 32'h0,         1, 32'd0,         0, 32'h0000_0000);
        add_vec(1, 1, 32'h8000_0000, 1, 32'h7FFF_FFFF, 0, 32'h8000_0000);
        add_vec(0, 0, 32'h0,         0, 32'd0,         1, 32'h0000_0000);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst)  do_reset;
            if (vt[i].shf)  shift_x(vt[i].x);
            if (vt[i].pass) run_pass(vt[i].e, -1, $sformatf("v%0d", i));
            read_w(vt[i].addr, d);
            check($sformatf("v%0d w[%0d]", i, vt[i].addr), d, vt[i].exp_w);
        end

        // ---- reset mid-pass ----
        do_reset;
        shift_x(32'd1);
        run_pass(32'd4096, -1, "pre-abort");
        read_w(0, d); check("pre-abort w[0]", d, 32'd1);
        @(negedge clk);
        start = 1'b1;
        err   = 32'd4096;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mid-pass busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        read_w(0, d); check("abort w[0]", d, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- overrun and ignored start during SWEEP ----
        do_reset;
        shift_x(32'd5);
        run_pass(32'd4096, 3, "ovr");
        check("ovr sticky", 32'(overrun), 32'd1);
        read_w(0, d); check("ovr w[0]", d, 32'd5);
        run_pass(32'd4096, -1, "ovr2");
        read_w(0, d); check("ovr2 w[0]", d, 32'd9);
        read_w(1, d); check("ovr2 w[1]", d, 32'd0);
        check("ovr2 sticky", 32'(overrun), 32'd1);
        do_reset;
        #1;
        check("ovr cleared", 32'(overrun), 32'd0);

        // ---- read of the tap being written ----
        shift_x(32'd1);
        w_rd_addr = '0;
        @(negedge clk);
        start = 1'b1;
        err   = 32'd4096;
        @(posedge clk); #1;
        start = 1'b0;
        check("rdw old", w_rd_data, 32'd0);
        @(posedge clk); #1;
        check("rdw new", w_rd_data, 32'd1);
        wait_idle("rdw");

        // ---- start and x_valid together in IDLE ----
        do_reset;
        @(negedge clk);
        x_valid = 1'b1;
        x_in    = 32'd3;
        start   = 1'b1;
        err     = 32'd4096;
        @(posedge clk); #1;
        x_valid = 1'b0;
        start   = 1'b0;
        check("same-cycle busy", 32'(busy), 32'd1);
        check("same-cycle no overrun", 32'(overrun), 32'd0);
        wait_idle("same-cycle");
        read_w(0, d); check("same-cycle w[0]", d, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lms_weight_update.md
# lms_weight_update

Leaky-LMS coefficient update engine for the adaptive noise-cancelling filter. It holds the reference-signal delay line and the N-tap weight bank. Each update pass applies the 0.999 leak to every weight and adds the scaled error-times-reference correction. It sits downstream of the error-sample stage and feeds coefficients to the FIR convolution stage through a read port.

## Interface
- N_TAPS, 16, number of taps and weights (2..256)
- W, 32, sample, error and weight width (signed, Q1.31)
- MU_SHIFT, 12, step size mu = 2^-MU_SHIFT, applied as an arithmetic right shift
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- x_valid  in  1  one-cycle strobe: shift x_in into the delay line
- x_in  in  W  new reference sample (signed)
- start  in  1  one-cycle strobe: begin an update pass using err
- err  in  W  error sample (signed), sampled on the start edge
- busy  out  1  update pass in progress
- done  out  1  one-cycle pulse when the pass completes
- overrun  out  1  sticky flag: x_valid arrived while busy
- w_rd_addr  in  $clog2(N_TAPS)  weight read index
- w_rd_data  out  W  combinational read of w[w_rd_addr]; returns 0 when the index is ≥ N_TAPS

## Operation
- **Delay line.** On x_valid while busy=0: x[0] ← x_in and x[k] ← x[k-1]. If x_valid arrives while busy=1, the sample is dropped and overrun is set. overrun clears only on reset.
- **FSM states.** IDLE, SWEEP, DONE.
  - IDLE → SWEEP on start: err is latched and idx is set to 0.
  - SWEEP: on each edge, w[idx] ← update(w[idx], x[idx]) and idx increments. After the write to idx = N_TAPS-1, go to DONE.
  - DONE → IDLE unconditionally after one cycle.
- **Ignored start.** start is ignored outside IDLE. start and x_valid in the same IDLE cycle: the shift happens, and the pass uses the post-shift delay line from the next cycle on.
- **Update arithmetic**, per tap:
  - leak = (w × LEAK_NUM) / LEAK_DEN, with a 64-bit signed intermediate; division truncates toward zero; result is 32-bit.
  - delta = (err_l × x[k]) >>> MU_SHIFT on a 64-bit signed product, then clamped to [0x80000000, 0x7FFFFFFF].
  - sum = leak + delta, computed in 33 bits. The result is narrowed to W bits as described under Configuration.
- **Reset.** Asserting rst_n low at any time, including mid-pass, aborts the pass. Reset values: all weights 0, all delay taps 0, state IDLE, idx 0, busy 0, done 0, overrun 0.

## Timing
- start sampled at edge 0. Weight writes occur at edges 1..N_TAPS.
- busy = 1 from edge 0 to edge N_TAPS+1.
- done = 1 for the single cycle between edges N_TAPS and N_TAPS+1.
- Pass latency is N_TAPS+1 cycles from start to done falling; back-to-back start is accepted on the cycle after done.
- w_rd_data has zero latency. A read of the tap being written in the same cycle returns the old value.
- busy and done are registered outputs. overrun is registered and asserts one edge after the offending x_valid.

## Configuration
- LMS_WEIGHT_SAT_EN:
  - Defined: the 33-bit sum is saturated to 0x7FFFFFFF on positive overflow and to 0x80000000 on negative overflow.
  - Undefined: the low 32 bits are kept (two's-complement wrap).
- The delta clamp is always present in both builds.

## Structure
- **Package lms_pkg:**
  - W
  - LEAK_NUM = 32'h7FDF3B63
  - LEAK_DEN = 32'h7FFFFFFF
  - the 64-bit product type
  - the FSM state enum {IDLE, SWEEP, DONE}
  - sat32 helper function
- **Sub-module lms_tap_update:** purely combinational single-tap datapath (leak, delta, sum, optional saturation) with inputs w, x, err and output w_new. The top level holds the FSM, idx, delay line, weight bank and read mux.

## Test plan
- **Reset mid-pass.** Reset, then pulse start with err=0 → busy high for N_TAPS+1 cycles, done pulses once, all weights read 0. Assert rst_n low mid-pass → busy, done and weights return to 0 immediately.
- **Basic correction.** Shift in x=1 once, start with err=4096 (MU_SHIFT=12) → w[0]=1, all other weights 0. A second pass with err=0 → w[0]=0 (leak truncation).
- **Saturation / wrap.** x[0]=0x7FFFFFFF, err=0x7FFFFFFF → delta is clamped and w[0]=0x7FFFFFFF. Repeat the pass → w[0]=0x7FFFFFFF with LMS_WEIGHT_SAT_EN, or 0xFFDF3B62 without it.
- **Leak with err=0.** From w[0]=0x7FFFFFFF (saturating build), a pass with err=0 → w[0]=0x7FDF3B63.
- **Overrun.** Pulse x_valid during SWEEP → delay line unchanged and overrun=1 persisting until reset. Pulse start during SWEEP → ignored, with exactly one done pulse.
- **Read port.** w_rd_addr=N_TAPS (when N_TAPS is not a power of 2) → w_rd_data=0. Read of the tap being written → old value in the write cycle and the new value on the next cycle.
